// File: rtl/cp0_exc_ctrl_if.sv
// CP0 write-port bus shared between the pipeline's mtc0 requester and the
// exception sequencer. The master side is the pipeline/CP0 environment and
// the slave side is cp0_exc_ctrl, which arbitrates and owns the write port.
interface cp0_exc_ctrl_if;
    logic        mtc0_req_i;
    logic [4:0]  mtc0_addr_i;
    logic [31:0] mtc0_data_i;
    logic        mtc0_gnt_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    modport master (
        output mtc0_req_i,
        output mtc0_addr_i,
        output mtc0_data_i,
        input  mtc0_gnt_o,
        input  we_o,
        input  waddr_o,
        input  wdata_o
    );

    modport slave (
        input  mtc0_req_i,
        input  mtc0_addr_i,
        input  mtc0_data_i,
        output mtc0_gnt_o,
        output we_o,
        output waddr_o,
        output wdata_o
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer and write-port arbiter.
// Accepts an exception, interrupt or eret from the MEM stage, then walks the
// CP0 EPC/Cause/Status updates through the single write port before
// flushing the pipeline and redirecting fetch. While idle it grants the
// pipeline's mtc0 requests onto the same port.
// Optional build macro TIMER_INT_EN: when defined, timer_int_i is folded into
// the pending-interrupt term as IP7 (masked by status_i[15]); otherwise the
// timer is only visible through cause_i.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR      = 32'h00000020,
    parameter logic [4:0]  CP0_EPC_ADDR    = 5'd14,
    parameter logic [4:0]  CP0_CAUSE_ADDR  = 5'd13,
    parameter logic [4:0]  CP0_STATUS_ADDR = 5'd12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_valid_i,
    input  logic [31:0]          pc_i,
    input  logic                 in_delayslot_i,
    input  logic [4:0]           exc_i,
    input  logic [31:0]          status_i,
    input  logic [31:0]          cause_i,
    input  logic [31:0]          epc_i,
    input  logic                 timer_int_i,
    cp0_exc_ctrl_if.slave        mtc0_bus,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic [31:0]          new_pc_o
);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STATUS,
        W_STATUS_CLR,
        REDIRECT
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [4:0]  code_q;
    logic        bd_q;
    logic        eret_q;
    logic        guard_q;

    logic [4:0]  code_d;
    logic        eret_d;
    logic [7:0]  ip_raw;
    logic        int_pending;
    logic        accept;

    logic        we_d;
    logic [4:0]  waddr_d;
    logic [31:0] wdata_d;

    logic        unused_ok;

`ifdef TIMER_INT_EN
    assign ip_raw    = cause_i[15:8] | {timer_int_i, 7'b0};
    assign unused_ok = ^{cause_i[31], cause_i[6:2]};
`else
    assign ip_raw    = cause_i[15:8];
    assign unused_ok = ^{cause_i[31], cause_i[6:2], timer_int_i};
`endif

    // An interrupt is taken only when enabled, not already in exception
    // level, and not right after an mtc0 that may have just changed the masks.
    assign int_pending = (|(ip_raw & status_i[15:8])) && !status_i[1]
                         && status_i[0] && !guard_q;

    assign accept = (state_q == IDLE) && inst_valid_i
                    && (int_pending || (exc_i != 5'd0));

    // Resolve the cause code by priority; eret only when nothing else applies.
    always_comb begin
        code_d = 5'd0;
        eret_d = 1'b0;
        if (int_pending) begin
            code_d = 5'd0;
        end else if (exc_i[0]) begin
            code_d = 5'd8;
        end else if (exc_i[1]) begin
            code_d = 5'd10;
        end else if (exc_i[2]) begin
            code_d = 5'd13;
        end else if (exc_i[3]) begin
            code_d = 5'd12;
        end else begin
            eret_d = 1'b1;
        end
    end

    // Next state, the write to be registered for the next cycle, and the
    // combinational stall/flush/redirect/grant outputs.
    always_comb begin
        state_d             = state_q;
        we_d                = 1'b0;
        waddr_d             = 5'd0;
        wdata_d             = 32'd0;
        stall_o             = 1'b0;
        flush_o             = 1'b0;
        new_pc_o            = 32'd0;
        mtc0_bus.mtc0_gnt_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall_o = 1'b1;
                    we_d    = 1'b1;
                    if (eret_d) begin
                        state_d = W_STATUS_CLR;
                        waddr_d = CP0_STATUS_ADDR;
                        wdata_d = status_i & ~32'h2;
                    end else if (!status_i[1]) begin
                        state_d = W_EPC;
                        waddr_d = CP0_EPC_ADDR;
                        wdata_d = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                    end else begin
                        state_d = W_CAUSE;
                        waddr_d = CP0_CAUSE_ADDR;
                        wdata_d = {in_delayslot_i, cause_i[30:7], code_d, cause_i[1:0]};
                    end
                end else if (mtc0_bus.mtc0_req_i) begin
                    mtc0_bus.mtc0_gnt_o = 1'b1;
                    we_d                = 1'b1;
                    waddr_d             = mtc0_bus.mtc0_addr_i;
                    wdata_d             = mtc0_bus.mtc0_data_i;
                end
            end
            W_EPC: begin
                stall_o = 1'b1;
                state_d = W_CAUSE;
                we_d    = 1'b1;
                waddr_d = CP0_CAUSE_ADDR;
                wdata_d = {bd_q, cause_i[30:7], code_q, cause_i[1:0]};
            end
            W_CAUSE: begin
                stall_o = 1'b1;
                state_d = W_STATUS;
                we_d    = 1'b1;
                waddr_d = CP0_STATUS_ADDR;
                wdata_d = status_i | 32'h2;
            end
            W_STATUS: begin
                stall_o = 1'b1;
                state_d = REDIRECT;
            end
            W_STATUS_CLR: begin
                stall_o = 1'b1;
                state_d = REDIRECT;
            end
            REDIRECT: begin
                flush_o  = 1'b1;
                new_pc_o = eret_q ? epc_i : EXC_VECTOR;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, registered write port, sequence context and mtc0 hazard guard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            code_q           <= 5'd0;
            bd_q             <= 1'b0;
            eret_q           <= 1'b0;
            guard_q          <= 1'b0;
            mtc0_bus.we_o    <= 1'b0;
            mtc0_bus.waddr_o <= 5'd0;
            mtc0_bus.wdata_o <= 32'd0;
        end else begin
            state_q          <= state_d;
            guard_q          <= mtc0_bus.mtc0_gnt_o;
            mtc0_bus.we_o    <= we_d;
            mtc0_bus.waddr_o <= waddr_d;
            mtc0_bus.wdata_o <= wdata_d;
            if (accept) begin
                code_q <= code_d;
                bd_q   <= in_delayslot_i;
                eret_q <= eret_d;
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model
// that plans each accepted sequence as a list of per-cycle expectations.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] EXC_VECTOR = 32'h00000020;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [4:0]  exc_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        timer_int_i;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    cp0_exc_ctrl_if bus();

    cp0_exc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid_i   (inst_valid_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .exc_i          (exc_i),
        .status_i       (status_i),
        .cause_i        (cause_i),
        .epc_i          (epc_i),
        .timer_int_i    (timer_int_i),
        .mtc0_bus       (bus),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        flush;
        logic        eret;
    } exp_t;

    exp_t        exp_q[$];
    logic        mw_valid;
    logic [4:0]  mw_addr;
    logic [31:0] mw_data;
    logic        guard;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        exp_q.delete();
        mw_valid = 1'b0;
        mw_addr  = 5'd0;
        mw_data  = 32'd0;
        guard    = 1'b0;
    endtask

    function automatic logic intPending();
        logic [7:0] ip;
        ip = cause_i[15:8];
`ifdef TIMER_INT_EN
        if (timer_int_i) ip[7] = 1'b1;
`endif
        return ((ip & status_i[15:8]) != 8'd0) && (status_i[1] == 1'b0)
               && (status_i[0] == 1'b1) && !guard;
    endfunction

    task automatic pushExp(input logic we, input logic [4:0] a, input logic [31:0] d,
                           input logic fl, input logic er);
        exp_t e;
        e.we = we; e.waddr = a; e.wdata = d; e.flush = fl; e.eret = er;
        exp_q.push_back(e);
    endtask

    // Plans the cycles following an accept from the architectural rules.
    task automatic planSequence();
        int          codes[4];
        logic [4:0]  code;
        logic        is_eret;
        logic [31:0] cause_val;
        codes = '{8, 10, 13, 12};
        code = 5'd0;
        is_eret = 1'b0;
        if (!intPending()) begin
            is_eret = 1'b1;
            for (int i = 3; i >= 0; i--) begin
                if (exc_i[i]) begin
                    code = 5'(codes[i]);
                    is_eret = 1'b0;
                end
            end
        end
        if (is_eret) begin
            pushExp(1'b1, 5'd12, status_i & 32'hFFFFFFFD, 1'b0, 1'b0);
            pushExp(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        end else begin
            if (status_i[1] == 1'b0)
                pushExp(1'b1, 5'd14, in_delayslot_i ? pc_i - 32'd4 : pc_i, 1'b0, 1'b0);
            cause_val = (cause_i & 32'h7FFFFF83) | (32'(in_delayslot_i) << 31) | (32'(code) << 2);
            pushExp(1'b1, 5'd13, cause_val, 1'b0, 1'b0);
            pushExp(1'b1, 5'd12, status_i | 32'h2, 1'b0, 1'b0);
            pushExp(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        end
    endtask

    // Compares every DUT output against the model for the current cycle and
    // advances the model across the coming clock edge.
    task automatic checkOutput();
        exp_t        e;
        logic        e_we, e_stall, e_flush, e_gnt;
        logic [4:0]  e_addr;
        logic [31:0] e_data, e_pc;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            e_we = e.we; e_addr = e.waddr; e_data = e.wdata;
            e_flush = e.flush; e_stall = !e.flush;
            e_pc = e.flush ? (e.eret ? epc_i : EXC_VECTOR) : 32'd0;
            e_gnt = 1'b0;
            mw_valid = 1'b0;
            guard = 1'b0;
        end else begin
            e_we = mw_valid; e_addr = mw_addr; e_data = mw_data;
            e_flush = 1'b0; e_pc = 32'd0;
            if (inst_valid_i && (intPending() || exc_i != 5'd0)) begin
                e_stall = 1'b1;
                e_gnt = 1'b0;
                planSequence();
                mw_valid = 1'b0;
                guard = 1'b0;
            end else begin
                e_stall = 1'b0;
                e_gnt = bus.mtc0_req_i;
                mw_valid = bus.mtc0_req_i;
                mw_addr = bus.mtc0_addr_i;
                mw_data = bus.mtc0_data_i;
                guard = bus.mtc0_req_i;
            end
        end
        cmp("gnt", 32'(bus.mtc0_gnt_o), 32'(e_gnt));
        cmp("we", 32'(bus.we_o), 32'(e_we));
        if (e_we) begin
            cmp("waddr", 32'(bus.waddr_o), 32'(e_addr));
            cmp("wdata", bus.wdata_o, e_data);
        end
        cmp("stall", 32'(stall_o), 32'(e_stall));
        cmp("flush", 32'(flush_o), 32'(e_flush));
        cmp("new_pc", new_pc_o, e_pc);
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic bd,
                                 input logic [4:0] exc, input logic [31:0] st,
                                 input logic [31:0] ca, input logic [31:0] ep,
                                 input logic req, input logic [4:0] addr,
                                 input logic [31:0] data);
        @(negedge clk);
        inst_valid_i = iv; pc_i = pc; in_delayslot_i = bd; exc_i = exc;
        status_i = st; cause_i = ca; epc_i = ep; timer_int_i = 1'b0;
        bus.mtc0_req_i = req; bus.mtc0_addr_i = addr; bus.mtc0_data_i = data;
        #1 checkOutput();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, pc_i, in_delayslot_i, 5'd0, status_i, cause_i, epc_i,
                      1'b0, 5'd0, 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        cmp({tag, "_we"}, 32'(bus.we_o), 32'd0);
        cmp({tag, "_waddr"}, 32'(bus.waddr_o), 32'd0);
        cmp({tag, "_wdata"}, bus.wdata_o, 32'd0);
        cmp({tag, "_stall"}, 32'(stall_o), 32'd0);
        cmp({tag, "_flush"}, 32'(flush_o), 32'd0);
        cmp({tag, "_new_pc"}, new_pc_o, 32'd0);
    endtask

    initial begin
        #2_000_000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int r;
        inst_valid_i = 1'b0; pc_i = 32'd0; in_delayslot_i = 1'b0; exc_i = 5'd0;
        status_i = 32'd0; cause_i = 32'd0; epc_i = 32'd0; timer_int_i = 1'b0;
        bus.mtc0_req_i = 1'b0; bus.mtc0_addr_i = 5'd0; bus.mtc0_data_i = 32'd0;
        modelReset();
        #2 checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] syscall sequence");
        applyStimulus(1'b1, 32'h100, 1'b0, 5'b00001, 32'h10000001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cmp("sys_T_stall", 32'(stall_o), 32'd1);
        idleCycle();
        cmp("sys_epc_addr", 32'(bus.waddr_o), 32'd14);
        cmp("sys_epc_data", bus.wdata_o, 32'h100);
        idleCycle();
        cmp("sys_cause_addr", 32'(bus.waddr_o), 32'd13);
        cmp("sys_cause_data", bus.wdata_o, 32'h00000020);
        idleCycle();
        cmp("sys_status_data", bus.wdata_o, 32'h10000003);
        cmp("sys_status_stall", 32'(stall_o), 32'd1);
        idleCycle();
        cmp("sys_flush", 32'(flush_o), 32'd1);
        cmp("sys_new_pc", new_pc_o, 32'h20);
        cmp("sys_redirect_stall", 32'(stall_o), 32'd0);
        repeat (2) idleCycle();

        $display("[TB] overflow in delay slot");
        applyStimulus(1'b1, 32'h204, 1'b1, 5'b01000, 32'h10000001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idleCycle();
        cmp("ov_epc_data", bus.wdata_o, 32'h200);
        idleCycle();
        cmp("ov_cause_data", bus.wdata_o, 32'h80000030);
        repeat (4) idleCycle();

        $display("[TB] interrupt accept and EXL block");
        applyStimulus(1'b1, 32'h300, 1'b0, 5'd0, 32'h10000401, 32'h400, 32'd0, 1'b0, 5'd0, 32'd0);
        cmp("int_stall", 32'(stall_o), 32'd1);
        idleCycle();
        cmp("int_epc_data", bus.wdata_o, 32'h300);
        idleCycle();
        cmp("int_cause_data", bus.wdata_o, 32'h400);
        repeat (4) idleCycle();
        applyStimulus(1'b1, 32'h300, 1'b0, 5'd0, 32'h10000403, 32'h400, 32'd0, 1'b0, 5'd0, 32'd0);
        cmp("int_exl_no_accept", 32'(stall_o), 32'd0);
        repeat (2) idleCycle();

        $display("[TB] eret");
        applyStimulus(1'b1, 32'h440, 1'b0, 5'b10000, 32'h10000003, 32'd0, 32'h380, 1'b0, 5'd0, 32'd0);
        cmp("eret_stall", 32'(stall_o), 32'd1);
        idleCycle();
        cmp("eret_status_addr", 32'(bus.waddr_o), 32'd12);
        cmp("eret_status_data", bus.wdata_o, 32'h10000001);
        idleCycle();
        cmp("eret_flush", 32'(flush_o), 32'd1);
        cmp("eret_new_pc", new_pc_o, 32'h380);
        repeat (2) idleCycle();

        $display("[TB] mtc0 arbitration");
        applyStimulus(1'b0, 32'h400, 1'b0, 5'd0, 32'h10000401, 32'h400, 32'd0, 1'b1, 5'd12, 32'h10000401);
        cmp("mtc0_gnt", 32'(bus.mtc0_gnt_o), 32'd1);
        applyStimulus(1'b1, 32'h400, 1'b0, 5'd0, 32'h10000401, 32'h400, 32'd0, 1'b0, 5'd0, 32'd0);
        cmp("mtc0_write_data", bus.wdata_o, 32'h10000401);
        cmp("mtc0_guard_no_int", 32'(stall_o), 32'd0);
        applyStimulus(1'b1, 32'h400, 1'b0, 5'd0, 32'h10000401, 32'h400, 32'd0, 1'b1, 5'd9, 32'hABCD);
        cmp("mtc0_int_after_guard", 32'(stall_o), 32'd1);
        cmp("mtc0_gnt_blocked_T", 32'(bus.mtc0_gnt_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h400, 1'b0, 5'd0, 32'h10000401, 32'h400, 32'd0, 1'b1, 5'd9, 32'hABCD);
            cmp("mtc0_gnt_blocked_seq", 32'(bus.mtc0_gnt_o), 32'd0);
        end
        applyStimulus(1'b0, 32'h400, 1'b0, 5'd0, 32'h10000401, 32'h400, 32'd0, 1'b1, 5'd9, 32'hABCD);
        cmp("mtc0_gnt_after_idle", 32'(bus.mtc0_gnt_o), 32'd1);
        applyStimulus(1'b0, 32'h400, 1'b0, 5'd0, 32'h10000001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cmp("mtc0_late_write_addr", 32'(bus.waddr_o), 32'd9);
        applyStimulus(1'b1, 32'h500, 1'b0, 5'b00001, 32'h10000001, 32'd0, 32'd0, 1'b1, 5'd12, 32'hFFFFFFFF);
        cmp("exc_mtc0_drop_gnt", 32'(bus.mtc0_gnt_o), 32'd0);
        idleCycle();
        cmp("exc_mtc0_drop_addr", 32'(bus.waddr_o), 32'd14);
        cmp("exc_mtc0_drop_data", bus.wdata_o, 32'h500);
        repeat (5) idleCycle();

        $display("[TB] reset during cause write");
        applyStimulus(1'b1, 32'h600, 1'b0, 5'b00001, 32'h10000001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idleCycle();
        idleCycle();
        cmp("rst_mid_we_before", 32'(bus.we_o), 32'd1);
        #1 rst = 1'b0;
        #1 checkResetOutputs("rst_mid");
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            idleCycle();
            cmp("rst_no_write", 32'(bus.we_o), 32'd0);
        end

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            inst_valid_i = 1'($urandom_range(0, 1));
            pc_i = $urandom & 32'hFFFFFFFC;
            in_delayslot_i = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 11));
            if (r < 5) exc_i = 5'(1 << r);
            else if (r == 5) exc_i = 5'($urandom);
            else exc_i = 5'd0;
            timer_int_i = ($urandom_range(0, 7) == 0);
            if (exp_q.size() == 0) begin
                status_i = $urandom;
                status_i[0] = ($urandom_range(0, 3) != 0);
                status_i[1] = ($urandom_range(0, 3) == 0);
                cause_i = $urandom;
                cause_i[15:8] = 8'(1 << $urandom_range(0, 11));
                epc_i = $urandom & 32'hFFFFFFFC;
            end
            bus.mtc0_req_i = ($urandom_range(0, 9) < 3);
            bus.mtc0_addr_i = 5'($urandom);
            bus.mtc0_data_i = $urandom;
            #1 checkOutput();
        end
        repeat (6) idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
